// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl
// Turns 8-bit position commands into a slew-limited PWM duty cycle for a
// hobby servo. A free-running period counter marks each PWM period. On every
// period boundary the duty cycle moves at most STEP clocks toward the
// commanded target. Once the target is reached, the block dwells for
// HOLD_PERIODS periods and then signals completion.
//
// Ports
//   clk         : single clock, rising-edge active
//   rst_n       : asynchronous active-low reset
//   cmd_valid   : a position command is offered
//   cmd_pos     : target position, 0 = DUTY_MIN .. 255 = DUTY_MAX
//   cmd_ready   : block is idle and will take a command
//   duty_cycle  : PWM high-time in clk cycles
//   period_tick : one-cycle pulse on the last cycle of each PWM period
//   busy        : a command is in progress (ramping or holding)
//   done        : one-cycle pulse after a command completes
module servo_ramp_ctrl #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned PERIOD       = 500_000,
  parameter int unsigned STEP         = 500,
  parameter int unsigned HOLD_PERIODS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_pos,
  output logic        cmd_ready,
  output logic [31:0] duty_cycle,
  output logic        period_tick,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DUTY_MIN = PERIOD / 20;
  localparam int unsigned DUTY_MAX = PERIOD / 10;

  localparam logic [47:0] DutySpan  = 48'(DUTY_MAX - DUTY_MIN);
  localparam logic [31:0] DutyMinW  = 32'(DUTY_MIN);
  localparam logic [31:0] LastCount = 32'(PERIOD - 1);
  localparam logic [31:0] StepW     = 32'(STEP);
  localparam logic [31:0] HoldW     = 32'(HOLD_PERIODS);

  // Reject parameter sets the timing scheme cannot support.
  if (PERIOD < 20) begin : g_bad_period
    $error("servo_ramp_ctrl: PERIOD must be at least 20");
  end
  if (STEP < 1) begin : g_bad_step
    $error("servo_ramp_ctrl: STEP must be at least 1");
  end
  if (CLK_FREQ == 0) begin : g_bad_clk
    $error("servo_ramp_ctrl: CLK_FREQ must be non-zero");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StHold
  } state_e;

  state_e      state;
  logic [31:0] period_cnt;
  logic [31:0] hold_cnt;
  logic [31:0] target;

  logic [31:0] cmd_target;
  logic        ramp_up;
  logic [31:0] ramp_dist;
  logic        ramp_last;
  logic [31:0] ramp_next;
  logic [31:0] hold_inc;

  // Period counter, free-running from reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (period_cnt == LastCount) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  assign period_tick = (period_cnt == LastCount);
  assign cmd_ready   = (state == StIdle);
  assign busy        = (state != StIdle);

  always_comb begin
    // The product is computed at 48 bits so a large PERIOD cannot overflow
    // before the divide.
    cmd_target = 32'(48'(DUTY_MIN) + (48'(cmd_pos) * DutySpan) / 48'd255);

    // Distance is taken as a magnitude so a downward ramp can never wrap
    // below the target.
    ramp_up   = (target > duty_cycle);
    ramp_dist = ramp_up ? (target - duty_cycle) : (duty_cycle - target);
    ramp_last = (ramp_dist <= StepW);
    if (ramp_last) begin
      ramp_next = target;
    end else if (ramp_up) begin
      ramp_next = duty_cycle + StepW;
    end else begin
      ramp_next = duty_cycle - StepW;
    end

    hold_inc = hold_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      hold_cnt   <= '0;
      duty_cycle <= DutyMinW;
      target     <= DutyMinW;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // A tick coinciding with acceptance is deliberately not used to
          // move the duty; ramping begins on the following tick.
          if (cmd_valid) begin
            target <= cmd_target;
            state  <= StRamp;
          end
        end
        StRamp: begin
          if (period_tick) begin
            duty_cycle <= ramp_next;
            if (ramp_last) begin
              hold_cnt <= '0;
              if (HOLD_PERIODS == 0) begin
                done  <= 1'b1;
                state <= StIdle;
              end else begin
                state <= StHold;
              end
            end
          end
        end
        StHold: begin
          if (period_tick) begin
            hold_cnt <= hold_inc;
            if (hold_inc == HoldW) begin
              done  <= 1'b1;
              state <= StIdle;
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter PERIOD, default 500_000, PWM period in clk cycles (PERIOD >= 20).
REQ-003 The block SHALL have parameter STEP, default 500, maximum duty change per PWM period in clk cycles (STEP >= 1).
REQ-004 The block SHALL have parameter HOLD_PERIODS, default 50, PWM periods to dwell at target before accepting the next command.
REQ-005 The block SHALL define DUTY_MIN = PERIOD/20 and DUTY_MAX = PERIOD/10 (integer division) as local constants.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port cmd_valid, input, 1 bit, a position command is offered.
REQ-009 The block SHALL have port cmd_pos, input, 8 bits, target position; 0 = DUTY_MIN, 255 = DUTY_MAX.
REQ-010 The block SHALL have port cmd_ready, output, 1 bit, the block can accept a command.
REQ-011 The block SHALL have port duty_cycle, output, 32 bits, high-time in clk cycles, driving the PWM duty input.
REQ-012 The block SHALL have port period_tick, output, 1 bit, one-cycle pulse on the last cycle of each PWM period.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port done, output, 1 bit, one-cycle pulse when a command completes.

Function
REQ-015 Period counter: counts 0..PERIOD-1 and wraps to 0; period_tick = 1 exactly while the count equals PERIOD-1.
REQ-016 FSM states: IDLE, RAMP, HOLD; cmd_ready = (state == IDLE); busy = (state != IDLE).
REQ-017 Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready; cmd_pos is ignored at all other times; there is no queue.
REQ-018 On acceptance: latch target = DUTY_MIN + floor(cmd_pos*(DUTY_MAX-DUTY_MIN)/255), computed at >= 40 bits without overflow; go to RAMP.
REQ-019 duty_cycle changes only on an edge where period_tick = 1, so each new value takes effect from count 0 of the next period.
REQ-020 RAMP, on each tick: if |target - duty_cycle| <= STEP, set duty_cycle = target and leave RAMP; otherwise move duty_cycle by exactly STEP toward target.
REQ-021 Leaving RAMP: if HOLD_PERIODS = 0, pulse done on the next cycle and go to IDLE; otherwise go to HOLD with hold count = 0.
REQ-022 HOLD, on each tick: increment the hold count; on the tick where the count reaches HOLD_PERIODS, pulse done on the next cycle and go to IDLE.
REQ-023 target equal to duty_cycle at acceptance: RAMP still consumes one tick before leaving.
REQ-024 Acceptance on the same edge as a tick: that tick does not move duty_cycle; ramping starts at the next tick.
REQ-025 duty_cycle SHALL always stay within [DUTY_MIN, DUTY_MAX]; no overshoot; no underflow on a downward ramp.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately (asynchronously) force: state IDLE, period count 0, hold count 0, duty_cycle = DUTY_MIN, target = DUTY_MIN, done = 0, period_tick = 0, busy = 0, cmd_ready = 1.
REQ-027 A reset during RAMP or HOLD SHALL abort the command with no done pulse; the period count restarts at 0 after release.

Verification (PERIOD=200, STEP=3, HOLD_PERIODS=2, so DUTY_MIN=10 and DUTY_MAX=20)
REQ-028 Reset release -> duty_cycle = 10, cmd_ready = 1, busy = 0; period_tick pulses every 200 cycles, first at count 199.
REQ-029 Accept cmd_pos=255 -> target 20; duty_cycle 13, 16, 19, 20 on successive ticks; HOLD for 2 ticks; done pulses once; busy falls; cmd_ready = 1.
REQ-030 From duty_cycle 20, accept cmd_pos=0 -> 17, 14, 11, 10; then cmd_pos=128 -> target 15, giving 13 then 15.
REQ-031 cmd_valid held high during RAMP and HOLD with a different cmd_pos -> ignored; the next command is accepted only on the first IDLE cycle.
REQ-032 Assert rst_n = 0 mid-ramp at duty_cycle 16 -> duty_cycle = 10 immediately, no done pulse, state IDLE.
REQ-033 Accept cmd_pos equal to the current position -> duty_cycle unchanged; done follows after 1 + 2 ticks; a command accepted on a tick edge -> no duty change on that tick.
